// File: rtl/sat_accum_pkg.sv
// sat_accum_pkg
// Shared types, saturation limits and the overflow detector used by the
// saturating accumulator scheduler. Limits are produced as 64-bit patterns
// so a module with any operand width up to 64 can slice off its own P bits.
package sat_accum_pkg;

  localparam int P_DEFAULT = 32;
  localparam int N_DEFAULT = 4;
  localparam int MAX_W     = 64;

  // Default-width accumulator word and requester index.
  typedef logic [P_DEFAULT-1:0]         acc_t;
  typedef logic [$clog2(N_DEFAULT)-1:0] id_t;

  // Largest positive two's complement value of width w: 0111...1
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of width w: 1000...0
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Signed overflow: both operands share a sign and the wrapped sum does not.
  function automatic logic ovf(input logic a_sign, input logic b_sign,
                               input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/bitwise_add.sv
// bitwise_add
// Plain wrapping two's complement adder. Saturation is layered on top by the
// caller so the adder itself stays a simple reusable block.
// Ports:
//   a, b  in  P  operands
//   sum   out P  a + b modulo 2^P
module bitwise_add #(
  parameter int P = 32
) (
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  output logic [P-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/sat_accum_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The search begins at ptr and walks
// upward with wrap-around; the first eligible requester wins. The pointer
// register itself lives in the parent so it can decide when to advance.
// Ports:
//   eligible   in  N          requesters allowed to win this cycle
//   ptr        in  clog2(N)   highest-priority index this cycle
//   grant      out N          one-hot winner, zero if nobody eligible
//   grant_idx  out clog2(N)   index of the winner (0 when no grant)
//   any_grant  out 1          a winner exists
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any_grant && eligible[idx]) begin
        any_grant      = 1'b1;
        grant_idx      = idx;
        grant[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sat_accum_scheduler.sv
// sat_accum_scheduler
// N requesters share one saturating adder. Each requester streams signed
// P-bit beats into its own accumulator; the beat flagged last produces a
// saturated packet sum on a single valid/ready result port together with the
// requester id and a sticky flag telling whether any beat saturated.
// Ports:
//   clk        in  1        clock
//   rst        in  1        synchronous reset, active-high
//   req_valid  in  N        per-requester beat valid
//   req_ready  out N        beat accepted (combinational, one-hot or zero)
//   req_data   in  N*P      per-requester operand, requester i at [i*P +: P]
//   req_last   in  N        beat closes the requester's packet
//   res_valid  out 1        result valid
//   res_ready  in  1        downstream accepts result
//   res_data   out P        saturated packet sum
//   res_id     out clog2(N) requester that produced the result
//   res_sat    out 1        saturation occurred somewhere in the packet
module sat_accum_scheduler
  import sat_accum_pkg::*;
#(
  parameter int P = 32,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*P-1:0]       req_data,
  input  logic [N-1:0]         req_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [P-1:0]         res_data,
  output logic [$clog2(N)-1:0] res_id,
  output logic                 res_sat
);

  localparam int IW = $clog2(N);

  localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(P);
  localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(P);
  localparam logic [P-1:0]     SAT_MAX_W    = SAT_MAX_FULL[P-1:0];
  localparam logic [P-1:0]     SAT_MIN_W    = SAT_MIN_FULL[P-1:0];

  logic [N-1:0][P-1:0] acc;
  logic [N-1:0]        sat;
  logic [IW-1:0]       ptr;

  logic                out_free;
  logic [N-1:0]        eligible;
  logic [N-1:0]        grant;
  logic [IW-1:0]       g;
  logic                any_grant;
  logic                g_last;
  logic                last_grant;
  logic [P-1:0]        op_a;
  logic [P-1:0]        op_b;
  logic [P-1:0]        raw_sum;
  logic                ov;
  logic [P-1:0]        sat_sum;

  // A last beat may only win when the result register can take it this
  // cycle; non-last beats never touch the output and so are never held back.
  assign out_free = !res_valid || res_ready;
  assign eligible = req_valid & (~req_last | {N{out_free}});

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (g),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Steer the winning requester's operand and last flag into the shared adder.
  always_comb begin
    op_b   = '0;
    g_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g == IW'(i)) begin
        op_b   = req_data[i*P +: P];
        g_last = req_last[i];
      end
    end
  end

  assign op_a       = acc[g];
  assign last_grant = any_grant && g_last;

  bitwise_add #(.P(P)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (raw_sum)
  );

  // Overflow can only happen with equal operand signs, so the accumulator's
  // sign alone tells which rail to clamp to.
  assign ov      = ovf(op_a[P-1], op_b[P-1], raw_sum[P-1]);
  assign sat_sum = ov ? (op_a[P-1] ? SAT_MIN_W : SAT_MAX_W) : raw_sum;

  // Accumulator bank and round-robin pointer. A last beat clears its lane so
  // the requester's next packet starts from zero on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sat <= '0;
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
      if (g_last) begin
        acc[g] <= '0;
        sat[g] <= 1'b0;
      end else begin
        acc[g] <= sat_sum;
        sat[g] <= sat[g] | ov;
      end
    end
  end

  // Result register. A new last grant reloads it even while the previous
  // result is draining, which keeps back-to-back results bubble free.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_sat   <= 1'b0;
    end else if (last_grant) begin
      res_valid <= 1'b1;
      res_data  <= sat_sum;
      res_id    <= g;
      res_sat   <= sat[g] | ov;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sat_accum_scheduler.md
Name: sat_accum_scheduler

Overview:
- Shares one saturating adder (existing `bitwise_add`) among N requesters. Each requester streams signed P-bit operands ending in a `last` beat.
- Holds one accumulator per requester and arbitrates round-robin, one beat per cycle.
- Emits each finished saturated sum on a valid/ready result port.
- Sits between vector-producing lanes and downstream reduction/writeback logic.

Parameters:
- P, 32, operand/accumulator width (two's complement).
- N, 4, number of requesters (N>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N  per-requester beat valid.
- req_ready  out  N  per-requester beat accepted (combinational, one-hot or zero).
- req_data  in  N x P  per-requester signed operand.
- req_last  in  N  beat closes the requester's packet.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_data  out  P  saturated packet sum.
- res_id  out  $clog2(N)  requester index of result.
- res_sat  out  1  saturation occurred at any beat of the packet.

Behaviour:
- Reset: every output register goes to zero: res_valid=0, res_data=0, res_id=0, res_sat=0. Internal state also clears: acc[i]=0, sat[i]=0, ptr=0.
- A reset mid-packet discards all partial sums; there is no recovery of in-flight data.
- Eligibility: requester i is eligible when req_valid[i] and (!req_last[i] or out_free), where out_free = !res_valid | res_ready.
- Arbitration: round-robin over eligible requesters. Search starts at ptr and proceeds ptr, ptr+1, ... wrapping mod N.
- The winner g gets req_ready[g]=1; all other req_ready bits are 0.
- After a grant, ptr <= (g+1) mod N. With no grant, ptr holds.
- Adder: single shared instance computes s = sat_add(acc[g], req_data[g]).
  - Positive overflow clamps to 2^(P-1)-1; negative overflow clamps to -2^(P-1).
  - ovf = (acc[g] and data signs equal) and (raw sum sign differs).
- Non-last grant: acc[g] <= s; sat[g] <= sat[g] | ovf.
- Last grant:
  - Output register loads res_data <= s, res_id <= g, res_sat <= sat[g] | ovf, res_valid <= 1.
  - acc[g] <= 0 and sat[g] <= 0.
  - The next packet from g starts fresh the following cycle.
- A single-beat packet (last on the first beat) yields res_data = data.
- Latency: the result is visible the cycle after the last beat's handshake.
- Result port: once res_valid=1, res_data, res_id and res_sat are held stable until res_valid & res_ready.
  - On that handshake with no new last-grant, res_valid <= 0.
  - If drain and a new last-grant happen in the same cycle, the register reloads with res_valid staying 1 (back-to-back, no bubble).
- Backpressure: while the output is blocked, last beats are not granted. Non-last beats of any requester continue to be granted.
- A blocked last beat does not move ptr.
- Requesters may interleave packets freely; the accumulators are independent.
- Accumulation is a saturating, non-associative chain in beat arrival order.
- req_data and req_last of a non-granted requester are ignored. Requesters must hold the beat until granted.

Decomposition:
- Package sat_accum_pkg holds:
  - P-parametrised typedef for the accumulator word.
  - id_t typedef for the requester index.
  - Functions/constants SAT_MAX and SAT_MIN.
  - Overflow-detect function ovf(a, b, s).
- Reuse one `bitwise_add` instance for the datapath. The sticky-flag overflow detect sits beside it using the package function.
- One natural sub-module: rr_arbiter #(N), with inputs eligible and ptr, outputs grant one-hot, grant index and any_grant. It is purely combinational; ptr lives in the top.

Test Plan:
- P=8, N=2: req0 beats 10, 20, 30(last), res_ready=1 → req_ready[0] high each cycle; one cycle after the last beat, res_data=60, res_id=0, res_sat=0, for exactly 1 cycle.
- P=8: req0 beats 100, 50(last) → res_data=127, res_sat=1. Then req0 beats 1(last) → res_data=1, res_sat=0, confirming the accumulator and flag were cleared.
- P=8: req1 beats -100, -100(last) → res_data=-128, res_sat=1, res_id=1. Then req1 beats 127, -128(last) → res_data=-1, res_sat=0.
- N=2 contention: both requesters valid continuously; req0 sends 1, 1, 1(last), req1 sends 2, 2, 2(last) → grants alternate 0,1,0,1,0,1. Results are (id0, 3) then (id1, 6) on consecutive cycles, with no bubble.
- Backpressure: hold res_ready=0 with a pending result; req0 presents a last beat while req1 presents non-last beats → req_ready[0]=0, req1 is granted each cycle, and res_* stays stable. Raise res_ready → req0's last beat is granted in that same cycle and the new result appears the next cycle.
- Reset mid-packet: req0 sends 50 (non-last), assert rst for 1 cycle, then req0 sends 5(last) → res_data=5. All outputs read 0 during and right after the reset cycle.
